// File: rtl/serial_full_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_full_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must be able to hold 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder; the single time-shared cell of the serial adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock with a registered carry.
// Define SERIAL_FULL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_full_adder
    import serial_full_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_FULL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH:0]   sum_cat;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q;
    logic             fa_s, fa_c;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at sum[0].
    assign sum_cat = {fa_s, sum_q};
    assign sum_d   = sum_cat[WIDTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    carry_q <= cin;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + CW'(1);
                    sum_q   <= sum_d;
                    if (cnt_q == LAST) begin
                        cout_q  <= fa_c;
`ifdef SERIAL_FULL_ADDER_OVF_EN
                        // carry_q is the carry into the MSB on this edge.
                        ovf_q   <= carry_q ^ fa_c;
`endif
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: directed corners, random operands, backpressure, reset.
module tb_serial_full_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    logic         ovf;
`endif

    int cmp = 0;
    int err = 0;

    serial_full_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef SERIAL_FULL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit to);
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        to = !out_valid;
    endtask

    task automatic handshake_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 8'h12; b = 8'h34;
        repeat (3) @(posedge clk);
        #1;
        cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        cmp++; if (sum !== 8'h00) begin err++; $display("FAIL rst_sum got %h want 00", sum); end
        cmp++; if (cout !== 1'b0) begin err++; $display("FAIL rst_cout got %b want 0", cout); end
        cmp++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy got %b want 0", busy); end
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cmp++; if (in_ready !== 1'b1) begin err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic check_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                            input int hold);
        int lat; bit to; logic [W:0] exp;
        exp = ref_add(av, bv, cv);
        start_op(av, bv, cv);
        cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            err++; $display("FAIL %s_accept busy=%b in_ready=%b want 1/0", nm, busy, in_ready);
        end
        wait_done(lat, to);
        cmp++; if (to) begin err++; $display("FAIL %s_timeout out_valid never rose", nm); end
        cmp++; if (lat != W) begin err++; $display("FAIL %s_latency got %0d want %0d", nm, lat, W); end
        repeat (hold) begin @(posedge clk); #1; end
        cmp++; if ({cout, sum} !== exp) begin
            err++; $display("FAIL %s_result got cout=%b sum=%h want cout=%b sum=%h", nm, cout, sum, exp[W], exp[W-1:0]);
        end
`ifdef SERIAL_FULL_ADDER_OVF_EN
        cmp++; if (ovf !== ref_ovf(av, bv, cv)) begin
            err++; $display("FAIL %s_ovf got %b want %b", nm, ovf, ref_ovf(av, bv, cv));
        end
`endif
        handshake_out();
        cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            err++; $display("FAIL %s_release out_valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
        end
        cmp++; if ({cout, sum} !== exp) begin
            err++; $display("FAIL %s_held got %h want %h", nm, {cout, sum}, exp);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{8'h3C, 8'hFF, 8'hFF, 8'h7F, 8'h80};
        logic [W-1:0] vb [5] = '{8'h05, 8'h01, 8'hFF, 8'h01, 8'h80};
        logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) check_op($sformatf("dir%0d", i), va[i], vb[i], vc[i], 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            check_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    endtask

    task automatic test_back_to_back();
        int lat; bit to; logic [W:0] exp1;
        start_op(8'h10, 8'h20, 1'b0);
        wait_done(lat, to);
        cmp++; if (to) begin err++; $display("FAIL bp_timeout out_valid never rose"); end
        a = 8'hC8; b = 8'h64; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cmp++; if (sum !== 8'h30 || cout !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                err++; $display("FAIL bp_hold%0d sum=%h cout=%b in_ready=%b out_valid=%b want 30/0/0/1",
                                i, sum, cout, in_ready, out_valid);
            end
        end
        handshake_out();
        cmp++; if (in_ready !== 1'b1) begin err++; $display("FAIL bp_idle in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cmp++; if (busy !== 1'b1) begin err++; $display("FAIL bp_accept busy got %b want 1", busy); end
        exp1 = ref_add(8'hC8, 8'h64, 1'b1);
        wait_done(lat, to);
        cmp++; if (to || lat != W) begin err++; $display("FAIL bp_lat got %0d to=%0d want %0d", lat, to, W); end
        cmp++; if ({cout, sum} !== exp1) begin err++; $display("FAIL bp_result got %h want %h", {cout, sum}, exp1); end
        handshake_out();
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            err++; $display("FAIL midrst_outputs out_valid=%b busy=%b sum=%h cout=%b want 0/0/00/0",
                            out_valid, busy, sum, cout);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (2 * W) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        cmp++; if (seen) begin err++; $display("FAIL midrst_pulse out_valid rose after abandoned op"); end
        check_op("midrst_next", 8'h01, 8'h01, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_full_adder.md
Name: serial_full_adder

Overview:
Bit-serial N-bit adder, the addition counterpart of the team's full subtractor cell. It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake. It then computes the sum LSB-first, one full-adder bit per clock, using a registered carry. It returns sum and carry-out on a second valid/ready handshake. It is used in area-constrained datapaths where a single full-adder cell is time-shared.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  addend A
b  input  WIDTH  addend B
cin  input  1  carry-in
out_valid  output  1  sum and cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  (a+b+cin) mod 2^WIDTH
cout  output  1  carry-out of bit WIDTH-1
busy  output  1  high in RUN state

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1 after release.
  - out_valid=0, busy=0, sum=0, cout=0.
  - Internal shift registers, carry and counter cleared.
- FSM states:
  - IDLE: in_ready=1. in_valid&&in_ready at edge t0 loads A<=a, B<=b, carry<=cin, cnt<=0, then goes to RUN.
  - RUN: in_ready=0, busy=1. Each edge:
    - compute {c,s}=A[0]+B[0]+carry;
    - sum_reg<={s,sum_reg[WIDTH-1:1]};
    - A,B shift right; carry<=c; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. sum/cout hold stable until out_valid&&out_ready; that edge returns to IDLE and deasserts out_valid.
- Latency: operands accepted at edge t0; out_valid high after edge tWIDTH (WIDTH cycles). Min issue interval is WIDTH+2 cycles.
- sum/cout registers hold the last result after the DONE→IDLE transition. They are overwritten only bit-by-bit during the next RUN. Consumers sample only while out_valid=1.
- in_valid while in_ready=0 is ignored; no queuing.
- out_ready while not in DONE has no effect.
- out_ready held high in DONE: one-cycle out_valid pulse; the next operand is accepted no earlier than the following cycle (IDLE).
- WIDTH=1: RUN lasts exactly one cycle.
- Counter width is $clog2(WIDTH+1); no wrap occurs since it is cleared on every load.
- Reset mid-RUN or mid-DONE: the operation is abandoned, all outputs take their reset values, and no out_valid is produced.

Optional Feature:
SERIAL_FULL_ADDER_OVF_EN
- Defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow, computed as carry into bit WIDTH-1 XOR cout.
  - Registered on the last RUN edge and held with sum. Reset value 0.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_full_adder_pkg holds:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - localparam function for counter width.
- One natural sub-module: full_adder_bit, a combinational 1-bit full adder (a, b, cin → s, cout). It is instantiated once, at bit 0 of the shift registers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, sum=8'h00, cout=0, busy=0; in_ready=1 on the first cycle after release.
- a=8'h3C, b=8'h05, cin=0 → out_valid exactly 8 cycles after acceptance, sum=8'h41, cout=0 (ovf=0 if enabled).
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0. Also a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1 (macro defined); port absent when undefined.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands → sum/cout stable, in_ready=0, new operands not taken. After out_ready=1, the block returns to IDLE and accepts them the next cycle.
- Reset asserted at RUN cycle 4 of a=8'hAA, b=8'h55 → outputs go to reset values immediately, no out_valid pulse. A subsequent 8'h01+8'h01 yields sum=8'h02.
